// File: rtl/eaglesong_bit_matrix_engine_if.sv
// State bus (valid/ready on both sides) plus matrix row-write port for the
// Eaglesong bit-matrix engine.
interface eaglesong_bit_matrix_engine_if #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 32
);
  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_state;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_state;
  logic           busy;
  logic           mat_wr_en;
  logic [RW-1:0]  mat_wr_row;
  logic [N-1:0]   mat_wr_data;

  modport master (
    output in_valid, in_state, out_ready, mat_wr_en, mat_wr_row, mat_wr_data,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready, mat_wr_en, mat_wr_row, mat_wr_data,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/eaglesong_bit_matrix_engine.sv
// Sequential Eaglesong bit-matrix step: out[j] = XOR of in[k] where M[k*N+j] is set,
// LANES output words per cycle, matrix held in a writable register file.
module eaglesong_bit_matrix_engine #(
  parameter int unsigned    N           = 16,
  parameter int unsigned    W           = 32,
  parameter int unsigned    LANES       = 1,
  parameter logic [N*N-1:0] MATRIX_INIT =
    256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf
) (
  input logic                         clk,
  input logic                         rst_n,
  eaglesong_bit_matrix_engine_if.slave bus
);

  localparam int unsigned STEPS = N / LANES;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((N % LANES) != 0) begin : g_lanes_check
    $error("eaglesong_bit_matrix_engine: LANES=%0d does not divide N=%0d", LANES, N);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*W-1:0] in_q, in_d;
  logic [N*W-1:0] out_q, out_d;
  logic [N*N-1:0] mat_q, mat_d;
  logic           in_ready_q, out_valid_q, busy_q;

  logic [W-1:0]   acc;
  int unsigned    col;
  int unsigned    row_base;

  // Next-state, matrix write and per-lane column XOR reduction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_d     = in_q;
    out_d    = out_q;
    mat_d    = mat_q;
    acc      = '0;
    col      = 0;
    row_base = 32'(bus.mat_wr_row) * N;

    case (state_q)
      S_IDLE: begin
        // Matrix write lands at the accept edge, so the block sees it.
        if (bus.mat_wr_en && (32'(bus.mat_wr_row) < N)) begin
          mat_d[row_base +: N] = bus.mat_wr_data;
        end
        if (bus.in_valid) begin
          in_d    = bus.in_state;
          out_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          col = 32'(cnt_q) * LANES + l;
          acc = '0;
          for (int unsigned k = 0; k < N; k++) begin
            if (mat_q[k*N + col]) acc = acc ^ in_q[k*W +: W];
          end
          out_d[col*W +: W] = acc;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_q        <= '0;
      out_q       <= '0;
      mat_q       <= MATRIX_INIT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_q        <= in_d;
      out_q       <= out_d;
      mat_q       <= mat_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_eaglesong_bit_matrix_engine.sv
// Bench for eaglesong_bit_matrix_engine: three instances (LANES=1,4,16) share
// one stimulus stream and are checked against a column-XOR reference model.
module tb_eaglesong_bit_matrix_engine;

  localparam int unsigned N = 16;
  localparam int unsigned W = 32;
  localparam logic [N*N-1:0] INIT =
    256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           in_valid;
  logic           out_ready;
  logic [N*W-1:0] in_state;
  logic           mat_wr_en;
  logic [3:0]     mat_wr_row;
  logic [N-1:0]   mat_wr_data;

  int n_chk = 0;
  int n_bad = 0;
  logic [N*N-1:0] m_model;
  logic [N*W-1:0] exp_last;

  eaglesong_bit_matrix_engine_if #(.N(N), .W(W)) if_l1 ();
  eaglesong_bit_matrix_engine_if #(.N(N), .W(W)) if_l4 ();
  eaglesong_bit_matrix_engine_if #(.N(N), .W(W)) if_l16 ();

  assign if_l1.in_valid     = in_valid;
  assign if_l1.in_state     = in_state;
  assign if_l1.out_ready    = out_ready;
  assign if_l1.mat_wr_en    = mat_wr_en;
  assign if_l1.mat_wr_row   = mat_wr_row;
  assign if_l1.mat_wr_data  = mat_wr_data;
  assign if_l4.in_valid     = in_valid;
  assign if_l4.in_state     = in_state;
  assign if_l4.out_ready    = out_ready;
  assign if_l4.mat_wr_en    = mat_wr_en;
  assign if_l4.mat_wr_row   = mat_wr_row;
  assign if_l4.mat_wr_data  = mat_wr_data;
  assign if_l16.in_valid    = in_valid;
  assign if_l16.in_state    = in_state;
  assign if_l16.out_ready   = out_ready;
  assign if_l16.mat_wr_en   = mat_wr_en;
  assign if_l16.mat_wr_row  = mat_wr_row;
  assign if_l16.mat_wr_data = mat_wr_data;

  eaglesong_bit_matrix_engine #(.N(N), .W(W), .LANES(1))  dut_l1  (.clk(clk), .rst_n(rst_n), .bus(if_l1));
  eaglesong_bit_matrix_engine #(.N(N), .W(W), .LANES(4))  dut_l4  (.clk(clk), .rst_n(rst_n), .bus(if_l4));
  eaglesong_bit_matrix_engine #(.N(N), .W(W), .LANES(16)) dut_l16 (.clk(clk), .rst_n(rst_n), .bus(if_l16));

  // Index 0 = LANES 1, 1 = LANES 4, 2 = LANES 16.
  logic [2:0]     ov, ir, bz;
  logic [N*W-1:0] os [3];
  assign ov    = {if_l16.out_valid, if_l4.out_valid, if_l1.out_valid};
  assign ir    = {if_l16.in_ready,  if_l4.in_ready,  if_l1.in_ready};
  assign bz    = {if_l16.busy,      if_l4.busy,      if_l1.busy};
  assign os[0] = if_l1.out_state;
  assign os[1] = if_l4.out_state;
  assign os[2] = if_l16.out_state;

  function automatic int lanes_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  function automatic logic [N*W-1:0] ref_mix(input logic [N*W-1:0] st, input logic [N*N-1:0] m);
    logic [N*W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        if (m[k*N + j]) r[j*W +: W] = r[j*W +: W] ^ st[k*W +: W];
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_state();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction

  task automatic mat_write(input int row, input logic [N-1:0] data);
    @(negedge clk);
    mat_wr_en   = 1'b1;
    mat_wr_row  = 4'(row);
    mat_wr_data = data;
    @(negedge clk);
    mat_wr_en   = 1'b0;
  endtask

  // Accept st, optionally strobe a row-0 write wr_cyc cycles later, wait for all DONE.
  task automatic start_wait(input logic [N*W-1:0] st, input int wr_cyc, input logic [N-1:0] wr_data);
    int lat [3];
    @(negedge clk);
    n_chk++;
    if (ir !== 3'b111) begin
      $display("FAIL accept_ready got=%b exp=111", ir);
      n_bad++;
    end
    in_valid  = 1'b1;
    in_state  = st;
    out_ready = 1'b0;
    exp_last  = ref_mix(st, m_model);
    @(negedge clk);
    in_valid = 1'b0;
    in_state = rand_state();
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mat_wr_en   = (cyc == wr_cyc);
      mat_wr_row  = 4'd0;
      mat_wr_data = wr_data;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (ov[i] === 1'b1 && lat[i] == 0) lat[i] = cyc;
      if (ov === 3'b111) break;
    end
    mat_wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (lat[i] != 16 / lanes_of(i)) begin
        $display("FAIL latency lanes=%0d got=%0d exp=%0d", lanes_of(i), lat[i], 16 / lanes_of(i));
        n_bad++;
      end
      n_chk++;
      if (os[i] !== exp_last) begin
        $display("FAIL result lanes=%0d got=%h exp=%h", lanes_of(i), os[i], exp_last);
        n_bad++;
      end
    end
    n_chk++;
    if (bz !== 3'b111 || ir !== 3'b000) begin
      $display("FAIL done_flags busy=%b in_ready=%b exp=111/000", bz, ir);
      n_bad++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (ir !== 3'b111 || ov !== 3'b000 || bz !== 3'b000) begin
      $display("FAIL drain_idle in_ready=%b out_valid=%b busy=%b exp=111/000/000", ir, ov, bz);
      n_bad++;
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (os[i] !== exp_last) begin
        $display("FAIL hold_after_done lanes=%0d got=%h exp=%h", lanes_of(i), os[i], exp_last);
        n_bad++;
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    n_chk++;
    if (ir !== 3'b111 || ov !== 3'b000 || bz !== 3'b000) begin
      $display("FAIL %s_flags in_ready=%b out_valid=%b busy=%b exp=111/000/000", tag, ir, ov, bz);
      n_bad++;
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (os[i] !== '0) begin
        $display("FAIL %s_out_state lanes=%0d got=%h exp=0", tag, lanes_of(i), os[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst_n   = 1'b1;
    m_model = INIT;
    @(negedge clk);
    check_idle_reset("post_reset");
  endtask

  task automatic test_default_vector();
    logic [N*W-1:0] st, exp_c;
    int idx [11] = '{0, 1, 2, 3, 5, 7, 8, 9, 10, 11, 15};
    st    = '0;
    st[0] = 1'b1;
    exp_c = '0;
    foreach (idx[n]) exp_c[idx[n]*W] = 1'b1;
    start_wait(st, 0, '0);
    n_chk++;
    if (os[0] !== exp_c) begin
      $display("FAIL default_vector got=%h exp=%h", os[0], exp_c);
      n_bad++;
    end
    drain();
  endtask

  task automatic test_random_sweep();
    for (int t = 0; t < 6; t++) begin
      start_wait(rand_state(), 0, '0);
      drain();
    end
  endtask

  task automatic test_identity();
    logic [N*W-1:0] st;
    for (int k = 0; k < N; k++) begin
      mat_write(k, N'(1) << k);
      m_model[k*N +: N] = N'(1) << k;
    end
    for (int k = 0; k < N; k++) st[k*W +: W] = 32'hA5A50000 + 32'(k);
    start_wait(st, 0, '0);
    n_chk++;
    if (os[0] !== st) begin
      $display("FAIL identity got=%h exp=%h", os[0], st);
      n_bad++;
    end
    drain();
  endtask

  task automatic test_backpressure();
    start_wait(rand_state(), 0, '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c % 2 == 0);
      in_state = rand_state();
      n_chk++;
      if (ov !== 3'b111 || ir !== 3'b000 || os[0] !== exp_last || os[2] !== exp_last) begin
        $display("FAIL backpressure c=%0d out_valid=%b in_ready=%b got=%h exp=%h", c, ov, ir, os[0], exp_last);
        n_bad++;
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    in_state = rand_state();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
      $display("FAIL mid_busy busy=%b out_valid=%b exp=1/0", bz[0], ov[0]);
      n_bad++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_reset("reset_mid");
    rst_n   = 1'b1;
    m_model = INIT;
    start_wait(rand_state(), 0, '0);
    drain();
  endtask

  task automatic test_ignored_write();
    start_wait(rand_state(), 1, 16'h0000);
    drain();
    mat_write(0, 16'h0000);
    m_model[0 +: N] = 16'h0000;
    start_wait(rand_state(), 0, '0);
    drain();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_state    = '0;
    mat_wr_en   = 1'b0;
    mat_wr_row  = '0;
    mat_wr_data = '0;
    m_model     = INIT;
    exp_last    = '0;
    test_reset();
    test_default_vector();
    test_random_sweep();
    test_identity();
    test_backpressure();
    test_reset_mid();
    test_ignored_write();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eaglesong_bit_matrix_engine.md
Name: eaglesong_bit_matrix_engine

Overview:
Sequential, parametrised successor to the constant Eaglesong bit-matrix lookup. It performs the full bit-matrix step of the Eaglesong permutation round over an N-word state. Each output word is the XOR of the input words selected by one matrix column, and LANES output words are produced per clock. The matrix is held in a writable register file that resets to the Eaglesong constant. The block sits between the permutation round controller and the circulant-multiplication stage, with valid/ready on both sides.

Parameters:
N, 16, state words per block; matrix is N×N bits.
W, 32, bits per state word.
LANES, 1, output words computed per cycle; must divide N (legal for N=16: 1, 2, 4, 8, 16).
MATRIX_INIT, 256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf, reset matrix contents; width N*N.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  in_state is valid.
in_ready  out  1  block can accept a state; high only in IDLE.
in_state  in  N*W  input words; word k = bits [k*W +: W].
out_valid  out  1  out_state is valid; high only in DONE.
out_ready  in  1  downstream accepts out_state.
out_state  out  N*W  result words; word j = bits [j*W +: W].
busy  out  1  high in BUSY or DONE.
mat_wr_en  in  1  matrix row write strobe.
mat_wr_row  in  clog2(N)  row index k.
mat_wr_data  in  N  new row k; bit j = matrix bit (k*N + j).

Behaviour:
- Matrix convention: bit index k*N+j (bit 0 = LSB of MATRIX_INIT) set means input word k contributes to output word j. out[j] = XOR over k of (M[k*N+j] ? in[k] : 0). Arithmetic is pure bitwise XOR, W bits wide; no carries.
- Reset (rst_n=0 at clk edge):
  - state goes to IDLE; in_ready=1, out_valid=0, busy=0, out_state=0.
  - Internal counter is cleared; matrix reloads MATRIX_INIT.
  - Reset mid-BUSY or mid-DONE abandons the block with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_state into an internal register, clear out_state and the counter c, and go to BUSY.
  - A matrix write in the same cycle as acceptance takes effect before the BUSY computation starts.
- BUSY (one cycle per step):
  - Compute output words c*LANES … c*LANES+LANES-1 from the captured state and the current matrix, and write them into out_state.
  - Increment c.
  - When c reaches N/LANES-1, go to DONE on the following edge.
  - in_ready=0, out_valid=0.
- DONE:
  - out_valid=1; out_state is held stable.
  - On out_ready=1, go to IDLE on that edge.
  - in_ready stays 0 during DONE, so there is no same-cycle accept on drain.
- Latency:
  - out_valid rises exactly N/LANES cycles after the acceptance edge: 16 cycles for N=16, LANES=1; 1 cycle for LANES=16.
  - Minimum initiation interval is N/LANES+2 cycles with out_ready held high.
- Matrix writes:
  - Accepted only in IDLE: M[k*N +: N] <= mat_wr_data at the edge.
  - mat_wr_en in BUSY or DONE is silently ignored, so the matrix is constant for the duration of a block.
  - Repeated writes to one row: the last write wins.
- in_state changes after acceptance have no effect.
- out_ready asserted outside DONE is ignored.
- out_state keeps its value after DONE until the next acceptance clears it.
- Parameter check: a simulation-time $error if N%LANES != 0.

Test Plan:
- Reset default, N=16/W=32/LANES=1: word0=32'h1, others 0 → after 16 cycles out_valid=1; words 0,1,2,3,5,7,8,9,10,11,15 = 32'h1, all others 0 (row 0 = 16'h8faf).
- Identity load: in IDLE write row k = (1<<k) for k=0..15, then input word k = 32'hA5A50000+k → out_state equals in_state bit-exactly.
- Latency sweep: LANES=1,4,16 with random in_state against a software reference of the Eaglesong bit matrix → out_valid exactly 16, 4 and 1 cycles after accept; results match.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and out_state stable, in_ready=0, and a new in_valid is not accepted; release out_ready → IDLE next cycle, in_ready=1.
- Ignored write: mat_wr_en with row 0 = 16'h0 during BUSY → result still matches the default matrix; the same write in IDLE afterwards → output word 0 of the next block uses the new row 0.
- Reset mid-operation: assert rst_n=0 at BUSY cycle 7 → next cycle IDLE, out_valid=0, out_state=0, in_ready=1, and the matrix is back to MATRIX_INIT after a prior identity load.
